param_ring_counter: RTL and testbench
=====================================

// Module: param_ring_counter
//
// PURPOSE
//   Parametrised shift-register counter. Generalises the fixed 4-bit one-hot ring
//   counter to any width, and adds a Johnson (twisted-ring) mode, up/down direction,
//   count enable, synchronous parallel load, illegal-state self-correction and a wrap
//   pulse. Used as a one-hot/thermometer sequencer and phase generator for datapath
//   control and lab demos.
//
// PARAMETERS
//   WIDTH  4  register width in bits; legal range 2..32
//   MODE   0  0 = ring (one-hot, WIDTH states); 1 = Johnson (2*WIDTH states)
//
// PORTS
//   clk       input   1      clock, rising edge
//   reset     input   1      asynchronous, active-high; forces SEED
//   en        input   1      count enable; one shift per enabled rising edge
//   dir       input   1      1 = up (shift toward MSB), 0 = down (shift toward LSB)
//   load      input   1      synchronous parallel load; has priority over en
//   load_val  input   WIDTH  value written on load
//   q         output  WIDTH  counter state, registered
//   wrap      output  1      registered 1-cycle pulse: counter stepped back to SEED
//   err       output  1      registered 1-cycle pulse: illegal state was corrected
//
// BEHAVIOUR
//   - SEED: ring = {{WIDTH-1{1'b0}},1'b1}; Johnson = all zeros.
//   - Reset: async, active-high. While high: q = SEED, wrap = 0, err = 0.
//     Deassertion is synchronous to clk. Reset mid-sequence abandons the current
//     state; the first enabled edge after release steps from SEED.
//   - Priority at each rising edge: reset > load > en > hold.
//   - load = 1: q <= load_val, unchecked (illegal values are accepted).
//     wrap = 0 and err = 0 on that edge. en is ignored.
//   - en = 1, load = 0, q legal:
//       ring up:   q <= {q[WIDTH-2:0], q[WIDTH-1]}
//       ring down: q <= {q[0], q[WIDTH-1:1]}
//       John up:   q <= {q[WIDTH-2:0], ~q[WIDTH-1]}
//       John down: q <= {~q[0], q[WIDTH-1:1]}
//   - Legal states:
//       ring:    exactly one bit set.
//       Johnson: q = 2^k-1, or q = ~(2^k-1), for some k in 0..WIDTH.
//   - en = 1, load = 0, q illegal: q <= SEED, err pulses 1 on the next cycle, wrap = 0.
//     No shift is performed on that edge.
//   - wrap = 1 for exactly one cycle when a legal enabled step produced q == SEED.
//     It is never set by a load, a reset or an error correction.
//   - en = 0, load = 0: q holds; wrap and err return to 0.
//   - Latency: q updates on the same edge that samples en/load. wrap and err are
//     valid in the same cycle as the new q.
//   - Direction changes take effect on the edge where dir is sampled; no extra state.
//   - Period: ring = WIDTH enabled steps; Johnson = 2*WIDTH enabled steps, either
//     direction.
//
// TESTING
//   1. WIDTH=4, MODE=0: reset -> q=0001, wrap=0, err=0; en=1, dir=1 for 4 edges ->
//      q=0010,0100,1000,0001; wrap=1 only after the 4th edge.
//   2. WIDTH=4, MODE=0, dir=0 from 0001 -> q=1000,0100,0010,0001; wrap on the 4th.
//   3. WIDTH=4, MODE=1, dir=1 for 8 edges from 0000 ->
//      0001,0011,0111,1111,1110,1100,1000,0000; wrap only on the 8th.
//      Then dir=0 from 0000 -> 1000,1100.
//   4. MODE=0: load=1, load_val=0110 -> q=0110, err=0; then en=1 -> q=0001, err=1,
//      wrap=0; next en -> q=0010, err=0. Repeat in MODE=1 with 0101.
//   5. load=1 and en=1 on the same edge with load_val=0100 -> q=0100 (no shift);
//      en=0 for 3 edges -> q holds 0100.
//   6. Assert reset asynchronously mid-cycle at q=1000 -> q=0001 immediately;
//      WIDTH=8 regression of scenarios 1 and 3 (periods 8 and 16).

Source files
------------

// File: rtl/param_ring_counter.sv
// param_ring_counter: width-parametrised one-hot ring / Johnson counter with up/down stepping,
// synchronous load, illegal-state recovery to SEED, and registered wrap/err pulses.
module param_ring_counter #(
    parameter int WIDTH = 4,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);
    localparam logic             JOHN = (MODE != 0);
    localparam logic [WIDTH-1:0] SEED = JOHN ? '0 : WIDTH'(1);
    logic [WIDTH-1:0] q_q, q_d, step;
    logic             wrap_q, wrap_d, err_q, err_d, legal;
    // Johnson legal states are the low-aligned thermometer codes and their complements
    always_comb begin
        legal  = JOHN ? (((q_q & (q_q + 1'b1)) == '0) || ((~q_q & (~q_q + 1'b1)) == '0))
                      : ((q_q != '0) && ((q_q & (q_q - 1'b1)) == '0));
        step   = dir ? {q_q[WIDTH-2:0], q_q[WIDTH-1] ^ JOHN} : {q_q[0] ^ JOHN, q_q[WIDTH-1:1]};
        q_d    = load ? load_val : !en ? q_q : legal ? step : SEED;
        wrap_d = !load && en && legal && (step == SEED);
        err_d  = !load && en && !legal;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= SEED;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end
    assign q    = q_q;
    assign wrap = wrap_q;
    assign err  = err_q;
endmodule

// File: tb/tb_param_ring_counter.sv
// tb_param_ring_counter: four counter configurations (4/8 bits, ring/Johnson) driven in lockstep
// and compared each cycle against a state-index reference model.
module tb_param_ring_counter;
    logic        clk = 1'b0, reset = 1'b0, en = 1'b0, dir = 1'b0, load = 1'b0;
    logic [31:0] load_val = '0;
    logic [3:0]  q0, q1;
    logic [7:0]  q2, q3;
    logic [3:0]  wr, er;
    logic [31:0] mq [4];
    logic        mw [4], me [4];
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    param_ring_counter #(.WIDTH(4), .MODE(0)) u0 (.clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val[3:0]), .q(q0), .wrap(wr[0]), .err(er[0]));
    param_ring_counter #(.WIDTH(4), .MODE(1)) u1 (.clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val[3:0]), .q(q1), .wrap(wr[1]), .err(er[1]));
    param_ring_counter #(.WIDTH(8), .MODE(0)) u2 (.clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val[7:0]), .q(q2), .wrap(wr[2]), .err(er[2]));
    param_ring_counter #(.WIDTH(8), .MODE(1)) u3 (.clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val[7:0]), .q(q3), .wrap(wr[3]), .err(er[3]));

    function automatic int wid(input int i);
        return i < 2 ? 4 : 8;
    endfunction

    function automatic int per(input int i);
        return (i % 2 == 1) ? 2 * wid(i) : wid(i);
    endfunction

    function automatic logic [31:0] mask(input int i);
        return (32'd1 << wid(i)) - 32'd1;
    endfunction

    // State k of the sequence: ring = one-hot at bit k; Johnson = k ones filling from LSB, then draining
    function automatic logic [31:0] state_of(input int i, input int k);
        if (i % 2 == 0) return 32'd1 << k;
        if (k <= wid(i)) return (32'd1 << k) - 32'd1;
        return ~((32'd1 << (k - wid(i))) - 32'd1) & mask(i);
    endfunction

    function automatic int index_of(input int i, input logic [31:0] v);
        for (int k = 0; k < per(i); k++) if (state_of(i, k) == v) return k;
        return -1;
    endfunction

    function automatic logic [31:0] dut_q(input int i);
        case (i)
            0: return {28'd0, q0};
            1: return {28'd0, q1};
            2: return {24'd0, q2};
            default: return {24'd0, q3};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("q[%0d]", i), dut_q(i), mq[i]);
            check($sformatf("wrap[%0d]", i), {31'd0, wr[i]}, {31'd0, mw[i]});
            check($sformatf("err[%0d]", i), {31'd0, er[i]}, {31'd0, me[i]});
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i] = state_of(i, 0);
            mw[i] = 1'b0;
            me[i] = 1'b0;
        end
    endtask

    task automatic step(input logic e, input logic d, input logic l, input logic [31:0] v);
        int k;
        @(negedge clk);
        en = e; dir = d; load = l; load_val = v;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            mw[i] = 1'b0;
            me[i] = 1'b0;
            if (l) mq[i] = v & mask(i);
            else if (e) begin
                k = index_of(i, mq[i]);
                if (k < 0) begin
                    mq[i] = state_of(i, 0);
                    me[i] = 1'b1;
                end else begin
                    k = d ? (k + 1) % per(i) : (k + per(i) - 1) % per(i);
                    mq[i] = state_of(i, k);
                    mw[i] = (k == 0);
                end
            end
        end
        #1 check_all();
    endtask

    // Reset asserted away from any clock edge must take effect before the next edge
    task automatic async_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clk);
        reset = 1'b0;
        en = 1'b0; load = 1'b0;
    endtask

    initial begin
        async_reset();
        repeat (8) step(1, 1, 0, 0);
        repeat (8) step(1, 0, 0, 0);
        repeat (16) step(1, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0);
        step(0, 1, 1, 32'h6);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 1, 32'h5);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h4);
        repeat (3) step(0, 0, 0, 0);
        async_reset();
        repeat (3) step(1, 1, 0, 0);
        async_reset();
        repeat (20) step(1, 1, 0, 0);
        for (int n = 0; n < 400; n++) begin
            logic [31:0] v;
            int k;
            k = $urandom_range(0, 7);
            v = (k == 0) ? $urandom : ((k == 1) ? state_of(3, $urandom_range(0, 15)) : state_of(2, $urandom_range(0, 7)));
            if ($urandom_range(0, 49) == 0) async_reset();
            else step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, v);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
